dmem_access_ctrl: RTL and testbench
===================================

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 The block SHALL have these parameters: ADDR_W, 64, address width; DATA_W, 64, data width; TIMEOUT_CYCLES, 255, cycles in REQ before an unacknowledged access is abandoned (legal range 1..255).
REQ-002 The block SHALL have these ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_re  in  1  MEM-stage load request.
- mem_we  in  1  MEM-stage store request; has priority over mem_re.
- mem_addr  in  ADDR_W  access address.
- mem_wdata  in  DATA_W  store data.
- mem_wmask  in  DATA_W/8  store byte enables.
- flush  in  1  MEM-stage kill (mode switch or exception).
- mem_stall  out  1  pipeline hold, consumed by the stall unit.
- mem_rdata  out  DATA_W  registered load data.
- rdata_valid  out  1  mem_rdata valid this cycle.
- access_fault  out  1  one-cycle fault pulse to the exception logic.
- fault_addr  out  ADDR_W  address of the faulting access.
- bus_req, bus_we  out  1 each  bus request and direction.
- bus_addr, bus_wdata, bus_wmask  out  ADDR_W / DATA_W / DATA_W/8  registered request fields.
- bus_ack, bus_err  in  1 each  completion, and error qualifier for bus_ack.
- bus_rdata  in  DATA_W  read data, valid with bus_ack.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, REQ, DONE, DRAIN.
REQ-004 IDLE, (mem_re|mem_we) & ~flush: latch address, wdata, wmask and bus_we = mem_we into the bus_* registers; next state REQ.
REQ-005 IDLE, flush, or no request: stay in IDLE; no fields latched.
REQ-006 bus_req SHALL be 1 only in REQ and DRAIN.
REQ-007 bus_* fields SHALL stay constant from entry to REQ until exit from REQ or DRAIN.
REQ-008 mem_stall SHALL be combinational: 1 in REQ; 1 in DRAIN; 1 in IDLE when (mem_re|mem_we) & ~flush; otherwise 0.
REQ-009 REQ, bus_ack & ~flush: capture bus_rdata into mem_rdata when bus_we=0; record bus_err; next state DONE.
REQ-010 DONE SHALL last exactly one cycle, then go to IDLE; mem_stall=0 in DONE, so a held instruction is never reissued.
REQ-011 In DONE: rdata_valid = ~bus_we & ~error & ~flush; access_fault = error & ~flush; fault_addr = bus_addr.
- error = recorded bus_err or timeout.
REQ-012 REQ, flush & ~bus_ack: go to DRAIN; the outstanding access SHALL complete on the bus and its result SHALL be discarded.
REQ-013 REQ, flush & bus_ack in the same cycle: go directly to IDLE; discard the result; no fault.
REQ-014 DRAIN, bus_ack: go to IDLE; no rdata_valid, no access_fault.
REQ-015 A counter SHALL clear on entry to REQ and increment each cycle in REQ or DRAIN without bus_ack.
REQ-016 When the counter reaches TIMEOUT_CYCLES with no bus_ack:
- REQ goes to DONE with error set.
- DRAIN goes to IDLE silently.
- bus_req drops the next cycle; the bus SHALL treat this drop as an abort.
REQ-017 Zero-wait bus (ack in the first REQ cycle): mem_stall high for exactly 2 cycles (IDLE, REQ); DONE follows on the third cycle.
REQ-018 mem_rdata SHALL hold its value outside capture cycles.
REQ-019 bus_ack or bus_err received in IDLE or DONE SHALL be ignored.

Reset
REQ-020 rst SHALL force IDLE and clear the counter, the error flag, mem_rdata, fault_addr and all bus_* registers to 0.
REQ-021 rst SHALL override every other input, including mid-transaction (REQ or DRAIN); bus_req, mem_stall (while mem_re=mem_we=0), rdata_valid and access_fault SHALL be 0 the cycle after rst.

Verification
REQ-022 Load, zero-wait: mem_re=1, addr=0x80, bus_ack with rdata=0xDEADBEEF in the first REQ cycle -> mem_stall 1,1,0; in DONE rdata_valid=1 and mem_rdata=0xDEADBEEF; no second bus_req.
REQ-023 Store, 3-cycle ack latency: mem_we=1, wmask=0x0F -> bus_we=1, bus_wmask=0x0F held for 3 cycles; mem_stall high 4 cycles; rdata_valid=0 throughout.
REQ-024 Error: bus_ack with bus_err=1, addr=0x1000 -> access_fault=1 for exactly one cycle in DONE, fault_addr=0x1000, rdata_valid=0.
REQ-025 Flush in flight: flush at REQ cycle 1, ack at cycle 4 -> DRAIN cycles 2-4; bus_req holds until the ack; IDLE after; no rdata_valid, no fault.
REQ-026 Timeout, TIMEOUT_CYCLES=4: no ack -> DONE after 4 REQ cycles with access_fault=1; bus_req=0 the following cycle.
REQ-027 rst asserted in REQ, then an ack arrives -> IDLE, bus_req=0, ack ignored, all outputs 0.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data memory access controller: turns a pipeline load/store into a
// single registered bus transaction, stalling the pipeline until it completes.
module dmem_access_ctrl #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_re,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wmask,
  input  logic                flush,
  output logic                mem_stall,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                rdata_valid,
  output logic                access_fault,
  output logic [ADDR_W-1:0]   fault_addr,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wmask,
  input  logic                bus_ack,
  input  logic                bus_err,
  input  logic [DATA_W-1:0]   bus_rdata
);

  // Bus handshake: bus_req is held with constant fields until bus_ack is seen
  // (bus_err qualifies that ack); bus_req dropping without an ack is an abort.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] cnt;
  logic       err_q;
  logic       req_in;
  logic       timeout_hit;

  assign req_in      = (mem_re | mem_we) & ~flush;
  // The cycle in which the counter would reach the limit, with no ack.
  assign timeout_hit = (cnt == CNT_LAST) & ~bus_ack;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_in) state_next = REQ;
      end
      REQ: begin
        if (bus_ack) begin
          state_next = flush ? IDLE : DONE;
        end else if (flush) begin
          state_next = timeout_hit ? IDLE : DRAIN;
        end else if (timeout_hit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      DRAIN: begin
        if (bus_ack || timeout_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus_req      = (state == REQ) || (state == DRAIN);
    mem_stall    = bus_req || ((state == IDLE) && req_in);
    rdata_valid  = (state == DONE) & ~bus_we & ~err_q & ~flush;
    access_fault = (state == DONE) & err_q & ~flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      err_q      <= 1'b0;
      mem_rdata  <= '0;
      fault_addr <= '0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_wmask  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req_in) begin
            bus_we    <= mem_we;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
            bus_wmask <= mem_wmask;
            cnt       <= 8'd0;
            err_q     <= 1'b0;
          end
        end
        REQ: begin
          if (bus_ack) begin
            // A flushed ack is discarded entirely: no data, no fault state.
            if (!flush) begin
              err_q <= bus_err;
              if (!bus_we) mem_rdata <= bus_rdata;
              if (bus_err) fault_addr <= bus_addr;
            end
          end else begin
            cnt <= cnt + 8'd1;
            if (timeout_hit && !flush) begin
              err_q      <= 1'b1;
              fault_addr <= bus_addr;
            end
          end
        end
        DRAIN: begin
          if (!bus_ack) cnt <= cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: table of complete load/store transactions plus
// hand-written flush, timeout and reset sequences.
module tb_dmem_access_ctrl;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_re;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wmask;
  logic          flush;
  logic          mem_stall;
  logic [DW-1:0] mem_rdata;
  logic          rdata_valid;
  logic          access_fault;
  logic [AW-1:0] fault_addr;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [MW-1:0] bus_wmask;
  logic          bus_ack;
  logic          bus_err;
  logic [DW-1:0] bus_rdata;

  dmem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .flush(flush), .mem_stall(mem_stall), .mem_rdata(mem_rdata),
    .rdata_valid(rdata_valid), .access_fault(access_fault),
    .fault_addr(fault_addr), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
    int            lat;
    logic          err;
    logic [DW-1:0] rdata;
    logic          exp_valid;
    logic          exp_fault;
    logic          chk_rdata;
    logic [DW-1:0] exp_rdata;
  } txn_t;

  txn_t tbl[5];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    mem_re = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0; mem_wmask = '0;
    flush = 0; bus_ack = 0; bus_err = 0; bus_rdata = '0;
  endtask

  task automatic idle_outputs_zero(input string tag);
    @(negedge clk);
    check({tag, "_bus_req"}, 64'(bus_req), 64'd0);
    check({tag, "_stall"}, 64'(mem_stall), 64'd0);
    check({tag, "_valid"}, 64'(rdata_valid), 64'd0);
    check({tag, "_fault"}, 64'(access_fault), 64'd0);
  endtask

  task automatic run_txn(input txn_t t, input int idx);
    string tag;
    tag = $sformatf("txn%0d", idx);
    mem_re = ~t.we; mem_we = t.we; mem_addr = t.addr;
    mem_wdata = t.wdata; mem_wmask = t.wmask;
    @(negedge clk);
    check({tag, "_idle_stall"}, 64'(mem_stall), 64'd1);
    check({tag, "_idle_bus_req"}, 64'(bus_req), 64'd0);
    next_cycle();
    for (int k = 1; k <= t.lat; k++) begin
      if (k == t.lat) begin
        bus_ack = 1; bus_err = t.err; bus_rdata = t.rdata;
      end
      @(negedge clk);
      check({tag, "_req_bus_req"}, 64'(bus_req), 64'd1);
      check({tag, "_req_stall"}, 64'(mem_stall), 64'd1);
      check({tag, "_req_bus_we"}, 64'(bus_we), 64'(t.we));
      check({tag, "_req_bus_addr"}, bus_addr, t.addr);
      check({tag, "_req_valid"}, 64'(rdata_valid), 64'd0);
      if (t.we) begin
        check({tag, "_req_wmask"}, 64'(bus_wmask), 64'(t.wmask));
        check({tag, "_req_wdata"}, bus_wdata, t.wdata);
      end
      next_cycle();
      bus_ack = 0; bus_err = 0; bus_rdata = '0;
    end
    @(negedge clk);
    check({tag, "_done_stall"}, 64'(mem_stall), 64'd0);
    check({tag, "_done_bus_req"}, 64'(bus_req), 64'd0);
    check({tag, "_done_valid"}, 64'(rdata_valid), 64'(t.exp_valid));
    check({tag, "_done_fault"}, 64'(access_fault), 64'(t.exp_fault));
    if (t.exp_fault) check({tag, "_fault_addr"}, fault_addr, t.addr);
    if (t.chk_rdata) check({tag, "_rdata"}, mem_rdata, t.exp_rdata);
    next_cycle();
    drive_idle();
    idle_outputs_zero({tag, "_after"});
    next_cycle();
  endtask

  initial begin
    tbl[0] = '{we:1'b0, addr:64'h80, wdata:64'h0, wmask:8'h00, lat:1, err:1'b0,
               rdata:64'hDEADBEEF, exp_valid:1'b1, exp_fault:1'b0,
               chk_rdata:1'b1, exp_rdata:64'hDEADBEEF};
    tbl[1] = '{we:1'b1, addr:64'h200, wdata:64'h1122334455667788, wmask:8'h0F,
               lat:3, err:1'b0, rdata:64'hFFFF, exp_valid:1'b0, exp_fault:1'b0,
               chk_rdata:1'b1, exp_rdata:64'hDEADBEEF};
    tbl[2] = '{we:1'b0, addr:64'h1000, wdata:64'h0, wmask:8'h00, lat:2, err:1'b1,
               rdata:64'h0, exp_valid:1'b0, exp_fault:1'b1,
               chk_rdata:1'b0, exp_rdata:64'h0};
    tbl[3] = '{we:1'b0, addr:64'hFFFF_FFFF_FFFF_FFF8, wdata:64'h0, wmask:8'h00,
               lat:4, err:1'b0, rdata:64'hCAFEF00D12345678, exp_valid:1'b1,
               exp_fault:1'b0, chk_rdata:1'b1, exp_rdata:64'hCAFEF00D12345678};
    tbl[4] = '{we:1'b1, addr:64'h3000, wdata:64'hA5A5, wmask:8'hF0, lat:1,
               err:1'b1, rdata:64'h0, exp_valid:1'b0, exp_fault:1'b1,
               chk_rdata:1'b1, exp_rdata:64'hCAFEF00D12345678};

    drive_idle();
    rst = 1;
    next_cycle();
    @(negedge clk);
    check("rst_bus_req", 64'(bus_req), 64'd0);
    check("rst_stall", 64'(mem_stall), 64'd0);
    check("rst_valid", 64'(rdata_valid), 64'd0);
    check("rst_fault", 64'(access_fault), 64'd0);
    check("rst_rdata", mem_rdata, 64'd0);
    check("rst_bus_addr", bus_addr, 64'd0);
    check("rst_fault_addr", fault_addr, 64'd0);
    next_cycle();
    rst = 0;

    // Stray ack/err in IDLE.
    bus_ack = 1; bus_err = 1; bus_rdata = 64'h1234;
    idle_outputs_zero("idle_ack");
    next_cycle();
    drive_idle();
    idle_outputs_zero("idle_ack_next");
    check("idle_ack_rdata", mem_rdata, 64'd0);
    next_cycle();

    // Flushed request in IDLE never starts.
    mem_we = 1; flush = 1; mem_addr = 64'h900;
    @(negedge clk);
    check("idle_flush_stall", 64'(mem_stall), 64'd0);
    next_cycle();
    drive_idle();
    idle_outputs_zero("idle_flush_next");
    next_cycle();

    for (int i = 0; i < 5; i++) run_txn(tbl[i], i);

    // Flush in REQ cycle 1, ack in cycle 4: result discarded.
    mem_re = 1; mem_addr = 64'h500;
    next_cycle();
    flush = 1;
    @(negedge clk);
    check("fl_req_bus_req", 64'(bus_req), 64'd1);
    check("fl_req_stall", 64'(mem_stall), 64'd1);
    next_cycle();
    flush = 0; mem_re = 0;
    for (int c = 2; c <= 4; c++) begin
      if (c == 4) begin
        bus_ack = 1; bus_rdata = 64'h5555;
      end
      @(negedge clk);
      check($sformatf("fl_drain%0d_bus_req", c), 64'(bus_req), 64'd1);
      check($sformatf("fl_drain%0d_stall", c), 64'(mem_stall), 64'd1);
      check($sformatf("fl_drain%0d_addr", c), bus_addr, 64'h500);
      next_cycle();
    end
    drive_idle();
    idle_outputs_zero("fl_after");
    check("fl_rdata_kept", mem_rdata, 64'hCAFEF00D12345678);
    next_cycle();

    // Flush then no ack: DRAIN times out silently.
    mem_re = 1; mem_addr = 64'h540;
    next_cycle();
    flush = 1;
    next_cycle();
    flush = 0; mem_re = 0;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("dto_drain%0d_bus_req", c), 64'(bus_req), 64'd1);
      next_cycle();
    end
    idle_outputs_zero("dto_after");
    next_cycle();

    // Flush and ack in the same REQ cycle.
    mem_re = 1; mem_addr = 64'h600;
    next_cycle();
    flush = 1; bus_ack = 1; bus_err = 1;
    @(negedge clk);
    check("flack_bus_req", 64'(bus_req), 64'd1);
    next_cycle();
    drive_idle();
    idle_outputs_zero("flack_after");
    next_cycle();

    // Timeout in REQ after 4 cycles.
    mem_re = 1; mem_addr = 64'h40;
    next_cycle();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("to_req%0d_bus_req", c), 64'(bus_req), 64'd1);
      next_cycle();
    end
    @(negedge clk);
    check("to_done_fault", 64'(access_fault), 64'd1);
    check("to_done_fault_addr", fault_addr, 64'h40);
    check("to_done_valid", 64'(rdata_valid), 64'd0);
    check("to_done_bus_req", 64'(bus_req), 64'd0);
    check("to_done_stall", 64'(mem_stall), 64'd0);
    next_cycle();
    drive_idle();
    idle_outputs_zero("to_after");
    next_cycle();

    // Reset in REQ, then a late ack.
    mem_re = 1; mem_addr = 64'h700;
    next_cycle();
    @(negedge clk);
    check("rreq_bus_req", 64'(bus_req), 64'd1);
    next_cycle();
    rst = 1; mem_re = 0;
    next_cycle();
    rst = 0; bus_ack = 1; bus_rdata = 64'h9999;
    idle_outputs_zero("rreq_after");
    check("rreq_bus_addr", bus_addr, 64'd0);
    check("rreq_rdata", mem_rdata, 64'd0);
    check("rreq_fault_addr", fault_addr, 64'd0);
    next_cycle();
    drive_idle();
    idle_outputs_zero("rreq_ack_ignored");
    check("rreq_rdata2", mem_rdata, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
